move_validator: RTL

Sequential chess move checker placed between the game-logic FSM and the 64-square board register. On a one-cycle request it checks a from/to square pair against the current board contents and returns a legality verdict plus a capture flag. Sliding pieces (rook, bishop, queen) walk the intermediate squares at one square per clock. The game logic uses the verdict to decide whether to commit the board change.

---
 rtl/move_validator_if.sv | 23 ++
 rtl/move_validator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/move_validator_if.sv
// Request/response bundle between the game-logic FSM and the move validator.
interface move_validator_if;
    logic [255:0] BOARD;
    logic         START;
    logic [5:0]   FROM_ADDR;
    logic [5:0]   TO_ADDR;
    logic         BUSY;
    logic         DONE;
    logic         VALID;
    logic         CAPTURE;

    // Game logic side: owns the board and issues requests.
    modport master (
        output BOARD, START, FROM_ADDR, TO_ADDR,
        input  BUSY, DONE, VALID, CAPTURE
    );

    // Validator side.
    modport slave (
        input  BOARD, START, FROM_ADDR, TO_ADDR,
        output BUSY, DONE, VALID, CAPTURE
    );
endinterface

// File: rtl/move_validator.sv
// Sequential chess move legality checker. Non-sliding pieces resolve in one
// CHECK cycle; rook/bishop/queen walk intermediate squares one per clock.
module move_validator #(
    parameter logic [2:0] WHITE_PAWN_ROW = 3'd6,
    parameter logic [2:0] BLACK_PAWN_ROW = 3'd1
) (
    input  logic            CLK,
    input  logic            RESET,
    move_validator_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WALK,
        S_RESP
    } state_t;

    localparam logic [2:0] P_PAWN   = 3'd1;
    localparam logic [2:0] P_KNIGHT = 3'd2;
    localparam logic [2:0] P_BISHOP = 3'd3;
    localparam logic [2:0] P_ROOK   = 3'd4;
    localparam logic [2:0] P_QUEEN  = 3'd5;
    localparam logic [2:0] P_KING   = 3'd6;

    state_t     state_q, state_d;
    logic [5:0] from_q, from_d;
    logic [5:0] to_q, to_d;
    logic [5:0] ptr_q, ptr_d;
    logic [2:0] step_r_q, step_r_d;
    logic [2:0] step_c_q, step_c_d;
    logic       dst_opp_q, dst_opp_d;
    logic       valid_q, valid_d;
    logic       capture_q, capture_d;

    // Piece codes 0 and 7 both mean an empty square.
    function automatic logic occ(input logic [3:0] sq);
        return (sq[2:0] != 3'd0) && (sq[2:0] != 3'd7);
    endfunction

    // Unit step (+1 / -1 / 0) in 3-bit modular form, from a signed delta.
    function automatic logic [2:0] sgn(input logic [3:0] d);
        if (d == 4'd0) return 3'd0;
        else if (d[3]) return 3'b111;
        else           return 3'b001;
    endfunction

    // Decoded square contents and row/col deltas for the latched request.
    logic [3:0] src_sq, dst_sq, mid_sq, ptr_sq;
    logic [3:0] dr, dc, adr, adc;
    logic       src_occ, dst_occ, dst_own, dst_opp;
    logic       white;
    logic [2:0] pawn_dir;
    logic [3:0] dir_one, dir_two;
    logic [2:0] start_row;
    logic [5:0] mid_addr;
    logic       geom_ok, pawn_ok, rook_ok, bishop_ok, sliding;

    assign src_sq   = bus.BOARD[{from_q, 2'b00} +: 4];
    assign dst_sq   = bus.BOARD[{to_q,   2'b00} +: 4];
    assign ptr_sq   = bus.BOARD[{ptr_q,  2'b00} +: 4];

    assign src_occ  = occ(src_sq);
    assign dst_occ  = occ(dst_sq);
    assign dst_own  = dst_occ && (dst_sq[3] == src_sq[3]);
    assign dst_opp  = dst_occ && (dst_sq[3] != src_sq[3]);

    // Deltas from row/col fields only, so a move never wraps an edge.
    assign dr  = {1'b0, to_q[5:3]} - {1'b0, from_q[5:3]};
    assign dc  = {1'b0, to_q[2:0]} - {1'b0, from_q[2:0]};
    assign adr = dr[3] ? (~dr + 4'd1) : dr;
    assign adc = dc[3] ? (~dc + 4'd1) : dc;

    assign white     = ~src_sq[3];
    assign pawn_dir  = white ? 3'b111 : 3'b001;
    assign dir_one   = white ? 4'hF : 4'h1;
    assign dir_two   = white ? 4'hE : 4'h2;
    assign start_row = white ? WHITE_PAWN_ROW : BLACK_PAWN_ROW;
    assign mid_addr  = {from_q[5:3] + pawn_dir, from_q[2:0]};
    assign mid_sq    = bus.BOARD[{mid_addr, 2'b00} +: 4];

    assign pawn_ok =
        ((dr == dir_one) && (dc == 4'd0) && !dst_occ) ||
        ((dr == dir_two) && (dc == 4'd0) && (from_q[5:3] == start_row) &&
         !occ(mid_sq) && !dst_occ) ||
        ((dr == dir_one) && (adc == 4'd1) && dst_opp);

    assign rook_ok   = (dr == 4'd0) ^ (dc == 4'd0);
    assign bishop_ok = (adr == adc);

    // Per-piece geometry; sliding pieces still need the path walk.
    always_comb begin
        geom_ok = 1'b0;
        sliding = 1'b0;
        case (src_sq[2:0])
            P_PAWN:   geom_ok = pawn_ok;
            P_KNIGHT: geom_ok = ((adr == 4'd1) && (adc == 4'd2)) ||
                                ((adr == 4'd2) && (adc == 4'd1));
            P_KING:   geom_ok = (adr <= 4'd1) && (adc <= 4'd1);
            P_BISHOP: begin geom_ok = bishop_ok;            sliding = 1'b1; end
            P_ROOK:   begin geom_ok = rook_ok;              sliding = 1'b1; end
            P_QUEEN:  begin geom_ok = rook_ok || bishop_ok; sliding = 1'b1; end
            default:  geom_ok = 1'b0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            from_q    <= '0;
            to_q      <= '0;
            ptr_q     <= '0;
            step_r_q  <= '0;
            step_c_q  <= '0;
            dst_opp_q <= 1'b0;
            valid_q   <= 1'b0;
            capture_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            from_q    <= from_d;
            to_q      <= to_d;
            ptr_q     <= ptr_d;
            step_r_q  <= step_r_d;
            step_c_q  <= step_c_d;
            dst_opp_q <= dst_opp_d;
            valid_q   <= valid_d;
            capture_q <= capture_d;
        end
    end

    // Next-state logic; verdict registers only change on entry to RESP.
    always_comb begin
        state_d   = state_q;
        from_d    = from_q;
        to_d      = to_q;
        ptr_d     = ptr_q;
        step_r_d  = step_r_q;
        step_c_d  = step_c_q;
        dst_opp_d = dst_opp_q;
        valid_d   = valid_q;
        capture_d = capture_q;
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    from_d  = bus.FROM_ADDR;
                    to_d    = bus.TO_ADDR;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                dst_opp_d = dst_opp;
                if (!src_occ || (from_q == to_q) || dst_own || !geom_ok) begin
                    valid_d   = 1'b0;
                    capture_d = 1'b0;
                    state_d   = S_RESP;
                end else if (sliding) begin
                    step_r_d = sgn(dr);
                    step_c_d = sgn(dc);
                    ptr_d    = {from_q[5:3] + sgn(dr), from_q[2:0] + sgn(dc)};
                    state_d  = S_WALK;
                end else begin
                    valid_d   = 1'b1;
                    capture_d = dst_opp;
                    state_d   = S_RESP;
                end
            end
            S_WALK: begin
                if (ptr_q == to_q) begin
                    valid_d   = 1'b1;
                    capture_d = dst_opp_q;
                    state_d   = S_RESP;
                end else if (occ(ptr_sq)) begin
                    valid_d   = 1'b0;
                    capture_d = 1'b0;
                    state_d   = S_RESP;
                end else begin
                    ptr_d = {ptr_q[5:3] + step_r_q, ptr_q[2:0] + step_c_q};
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.BUSY    = (state_q != S_IDLE);
    assign bus.DONE    = (state_q == S_RESP);
    assign bus.VALID   = valid_q;
    assign bus.CAPTURE = capture_q;

endmodule
